// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the UART ring-buffer AXI-Stream reader.
package axis_uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapture,
    StPresent
  } rd_state_e;

  localparam logic [1:0] KEEP_PAIR   = 2'b11;
  localparam logic [1:0] KEEP_SINGLE = 2'b01;

endpackage

// File: rtl/ring_flush_timer.sv
// Saturating idle counter: flags when a lone pending word has waited long enough.
module ring_flush_timer #(
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic occ_is_one,
  input  logic in_idle,
  output logic flush_due
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FLUSH_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (occ_is_one && in_idle) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With FLUSH_CYCLES=0 the counter sits at its maximum, so a single word goes out at once.
  assign flush_due = (cnt_q == CntMax);

endmodule

// File: rtl/axis_ring_reader.sv
// Ring-buffer read side: fetches word pairs (or a flushed single) and presents them on AXI-Stream.
module axis_ring_reader
  import axis_uart_pkg::*;
#(
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned ADDRWIDTH    = 10,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRWIDTH:0]    wr_ptr,
  output logic [ADDRWIDTH:0]    rd_ptr,
  output logic                  ram_en,
  output logic [ADDRWIDTH-1:0]  ram_raddr,
  input  logic [DWIDTH-1:0]     ram_dout1,
  input  logic [DWIDTH-1:0]     ram_dout2,
  output logic [2*DWIDTH-1:0]   m_axis_tdata,
  output logic [1:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam logic [ADDRWIDTH:0] PtrOne = (ADDRWIDTH + 1)'(1);
  localparam logic [ADDRWIDTH:0] PtrTwo = (ADDRWIDTH + 1)'(2);

  rd_state_e             state_q;
  logic [ADDRWIDTH:0]    rd_ptr_q;
  logic [ADDRWIDTH:0]    occ;
  logic                  pair_q;
  logic                  ram_en_q;
  logic                  tvalid_q;
  logic [2*DWIDTH-1:0]   tdata_q;
  logic [1:0]            tkeep_q;
  logic                  occ_is_one;
  logic                  in_idle;
  logic                  flush_due;

  // Modular difference of wrap-bit pointers gives 0..depth directly.
  assign occ        = wr_ptr - rd_ptr_q;
  assign occ_is_one = (occ == PtrOne);
  assign in_idle    = (state_q == StIdle);

  ring_flush_timer #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk        (clk),
    .rst        (rst),
    .occ_is_one (occ_is_one),
    .in_idle    (in_idle),
    .flush_due  (flush_due)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      pair_q   <= 1'b0;
      ram_en_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= 2'b00;
    end else begin
      ram_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Pair/single choice is frozen here; later writes wait for the next transfer.
          if (occ >= PtrTwo) begin
            pair_q   <= 1'b1;
            ram_en_q <= 1'b1;
            state_q  <= StFetch;
          end else if (occ_is_one && flush_due) begin
            pair_q   <= 1'b0;
            ram_en_q <= 1'b1;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          state_q <= StCapture;
        end
        StCapture: begin
          tdata_q  <= {(pair_q ? ram_dout2 : {DWIDTH{1'b0}}), ram_dout1};
          tkeep_q  <= pair_q ? KEEP_PAIR : KEEP_SINGLE;
          tvalid_q <= 1'b1;
          state_q  <= StPresent;
        end
        StPresent: begin
          if (m_axis_tready) begin
            rd_ptr_q <= rd_ptr_q + (pair_q ? PtrTwo : PtrOne);
            tvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_ptr        = rd_ptr_q;
  assign ram_en        = ram_en_q;
  assign ram_raddr     = rd_ptr_q[ADDRWIDTH-1:0];
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_ring_reader.sv
// Directed bench: a 1024-deep reader with flush timeout and an 8-deep reader for wrap-around.
module tb_axis_ring_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [10:0] wr_ptr_a, rd_ptr_a;
  logic        ram_en_a;
  logic [9:0]  raddr_a;
  logic [15:0] dout1_a, dout2_a;
  logic [31:0] tdata_a;
  logic [1:0]  tkeep_a;
  logic        tvalid_a, tready_a;

  logic [3:0]  wr_ptr_w, rd_ptr_w;
  logic        ram_en_w;
  logic [2:0]  raddr_w;
  logic [15:0] dout1_w, dout2_w;
  logic [31:0] tdata_w;
  logic [1:0]  tkeep_w;
  logic        tvalid_w, tready_w;

  logic [15:0] mem_a [1024];
  logic [15:0] mem_w [8];

  axis_ring_reader #(
    .DWIDTH       (16),
    .ADDRWIDTH    (10),
    .FLUSH_CYCLES (16)
  ) dut_a (
    .clk           (clk),
    .rst           (rst),
    .wr_ptr        (wr_ptr_a),
    .rd_ptr        (rd_ptr_a),
    .ram_en        (ram_en_a),
    .ram_raddr     (raddr_a),
    .ram_dout1     (dout1_a),
    .ram_dout2     (dout2_a),
    .m_axis_tdata  (tdata_a),
    .m_axis_tkeep  (tkeep_a),
    .m_axis_tvalid (tvalid_a),
    .m_axis_tready (tready_a)
  );

  axis_ring_reader #(
    .DWIDTH       (16),
    .ADDRWIDTH    (3),
    .FLUSH_CYCLES (0)
  ) dut_w (
    .clk           (clk),
    .rst           (rst),
    .wr_ptr        (wr_ptr_w),
    .rd_ptr        (rd_ptr_w),
    .ram_en        (ram_en_w),
    .ram_raddr     (raddr_w),
    .ram_dout1     (dout1_w),
    .ram_dout2     (dout2_w),
    .m_axis_tdata  (tdata_w),
    .m_axis_tkeep  (tkeep_w),
    .m_axis_tvalid (tvalid_w),
    .m_axis_tready (tready_w)
  );

  // Dual-word RAM models with one cycle of read latency and wrapping second address.
  always_ff @(posedge clk) begin
    if (ram_en_a) begin
      dout1_a <= mem_a[raddr_a];
      dout2_a <= mem_a[raddr_a + 10'd1];
    end
    if (ram_en_w) begin
      dout1_w <= mem_w[raddr_w];
      dout2_w <= mem_w[raddr_w + 3'd1];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_ptr_a = '0;
    wr_ptr_w = '0;
    tready_a = 1'b0;
    tready_w = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int found;
    int n_wait;

    for (int i = 0; i < 1024; i++) mem_a[i] = 16'h0;
    for (int i = 0; i < 8; i++) mem_w[i] = 16'h0;
    rst      = 1'b1;
    wr_ptr_a = '0;
    wr_ptr_w = '0;
    tready_a = 1'b0;
    tready_w = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_rd_ptr", rd_ptr_a, 0);
    check_eq("rst_tvalid", tvalid_a, 0);
    check_eq("rst_tdata", tdata_a, 0);
    check_eq("rst_tkeep", tkeep_a, 0);
    check_eq("rst_ram_en", ram_en_a, 0);
    check_eq("rst_w_rd_ptr", rd_ptr_w, 0);

    // Pair read
    do_reset();
    tready_a  = 1'b1;
    mem_a[0]  = 16'h1111;
    mem_a[1]  = 16'h2222;
    wr_ptr_a  = 11'd2;
    @(negedge clk);
    check_eq("pair_fetch_en", ram_en_a, 1);
    @(negedge clk);
    check_eq("pair_capture_ram_en", ram_en_a, 0);
    check_eq("pair_not_early", tvalid_a, 0);
    @(negedge clk);
    check_eq("pair_tvalid", tvalid_a, 1);
    check_eq("pair_tdata", tdata_a, 32'h2222_1111);
    check_eq("pair_tkeep", tkeep_a, 2'b11);
    @(negedge clk);
    check_eq("pair_tvalid_drop", tvalid_a, 0);
    check_eq("pair_rd_ptr", rd_ptr_a, 2);

    // Flush of a single word
    do_reset();
    tready_a = 1'b1;
    mem_a[0] = 16'hABCD;
    wr_ptr_a = 11'd1;
    bad = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (tvalid_a) bad++;
      if (i <= 16 && ram_en_a) bad++;
      if (i == 17) check_eq("flush_fetch_cycle", ram_en_a, 1);
    end
    check_eq("flush_quiet", bad, 0);
    @(negedge clk);
    check_eq("flush_tvalid", tvalid_a, 1);
    check_eq("flush_tdata", tdata_a, 32'h0000_ABCD);
    check_eq("flush_tkeep", tkeep_a, 2'b01);
    @(negedge clk);
    check_eq("flush_rd_ptr", rd_ptr_a, 1);

    // Backpressure
    do_reset();
    mem_a[0] = 16'h4444;
    mem_a[1] = 16'h3333;
    wr_ptr_a = 11'd2;
    repeat (3) @(negedge clk);
    check_eq("bp_tvalid", tvalid_a, 1);
    check_eq("bp_tdata", tdata_a, 32'h3333_4444);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tvalid_a !== 1'b1 || tdata_a !== 32'h3333_4444 || tkeep_a !== 2'b11 ||
          rd_ptr_a !== 11'd0) bad++;
    end
    check_eq("bp_stable", bad, 0);
    tready_a = 1'b1;
    @(negedge clk);
    check_eq("bp_done_tvalid", tvalid_a, 0);
    check_eq("bp_done_rd_ptr", rd_ptr_a, 2);

    // Late write during FETCH after a single-word decision
    do_reset();
    tready_a = 1'b1;
    mem_a[0] = 16'h5555;
    wr_ptr_a = 11'd1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (ram_en_a) found = 1;
    end
    check_eq("late_fetch_seen", found, 1);
    mem_a[1] = 16'h6666;
    wr_ptr_a = 11'd2;
    repeat (2) @(negedge clk);
    check_eq("late_first_tvalid", tvalid_a, 1);
    check_eq("late_first_tkeep", tkeep_a, 2'b01);
    check_eq("late_first_tdata", tdata_a, 32'h0000_5555);
    @(negedge clk);
    check_eq("late_first_rd_ptr", rd_ptr_a, 1);
    n_wait = 0;
    while (!tvalid_a && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("late_second_latency", n_wait, 19);
    check_eq("late_second_tdata", tdata_a, 32'h0000_6666);
    check_eq("late_second_tkeep", tkeep_a, 2'b01);
    @(negedge clk);
    check_eq("late_second_rd_ptr", rd_ptr_a, 2);

    // Reset while a beat is held in PRESENT
    do_reset();
    tready_a = 1'b1;
    mem_a[0] = 16'h0101;
    mem_a[1] = 16'h0202;
    wr_ptr_a = 11'd2;
    repeat (4) @(negedge clk);
    check_eq("mid_rst_pre_rd_ptr", rd_ptr_a, 2);
    tready_a = 1'b0;
    mem_a[2] = 16'h0303;
    mem_a[3] = 16'h0404;
    wr_ptr_a = 11'd4;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_pre_tvalid", tvalid_a, 1);
    #2;
    rst      = 1'b1;
    wr_ptr_a = '0;
    #1;
    check_eq("mid_rst_tvalid", tvalid_a, 0);
    check_eq("mid_rst_rd_ptr", rd_ptr_a, 0);
    check_eq("mid_rst_ram_en", ram_en_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap-around on the 8-deep instance
    do_reset();
    tready_w = 1'b1;
    for (int i = 0; i < 7; i++) mem_w[3'(i)] = 16'h0100 + 16'(i);
    wr_ptr_w = 4'd7;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      @(negedge clk);
      if (rd_ptr_w == 4'd7 && !tvalid_w) found = 1;
    end
    check_eq("wrap_reach_7", found, 1);
    mem_w[7] = 16'hAAAA;
    mem_w[0] = 16'hBBBB;
    wr_ptr_w = 4'd9;
    n_wait = 0;
    while (!tvalid_w && n_wait < 10) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("wrap_latency", n_wait, 3);
    check_eq("wrap_tdata", tdata_w, 32'hBBBB_AAAA);
    check_eq("wrap_tkeep", tkeep_w, 2'b11);
    @(negedge clk);
    check_eq("wrap_rd_ptr", rd_ptr_w, 4'b1001);
    for (int i = 1; i < 7; i++) mem_w[3'(i)] = 16'h0200 + 16'(i);
    wr_ptr_w = 4'd15;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      if (rd_ptr_w == 4'd15 && !tvalid_w) found = 1;
    end
    check_eq("wrap_reach_15", found, 1);
    mem_w[7] = 16'hCCCC;
    wr_ptr_w = 4'd0;
    n_wait = 0;
    while (!tvalid_w && n_wait < 10) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("roll_tdata", tdata_w, 32'h0000_CCCC);
    check_eq("roll_tkeep", tkeep_w, 2'b01);
    @(negedge clk);
    check_eq("roll_rd_ptr", rd_ptr_w, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_ring_reader.md
# axis_ring_reader

Read side of the UART block-RAM ring buffer. Tracks a read pointer against the writer's pointer and fetches two consecutive words per RAM access, using the RAM's dual-word read (`raddr` and `raddr+1`). Presents the result as a two-word AXI-Stream beat, or as a single-word beat after an idle flush timeout. Sits between the ring RAM and the downstream AXI-Stream consumer, in the same clock domain as the writer.

## Interface
- `DWIDTH`, 16: width of one stored word.
- `ADDRWIDTH`, 10: RAM address width; depth is 2**ADDRWIDTH.
- `FLUSH_CYCLES`, 16: idle cycles with exactly one word pending before it is sent alone. 0 means send immediately.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_ptr`  in  ADDRWIDTH+1  writer's pointer; the MSB is the wrap bit.
- `rd_ptr`  out  ADDRWIDTH+1  read pointer; MSB is the wrap bit; fed back to the writer for the full check.
- `ram_en`  out  1  read enable to the RAM.
- `ram_raddr`  out  ADDRWIDTH  equals `rd_ptr[ADDRWIDTH-1:0]`, combinational.
- `ram_dout1`  in  DWIDTH  word at `ram_raddr`, registered by the RAM.
- `ram_dout2`  in  DWIDTH  word at `ram_raddr+1` (mod depth), registered by the RAM.
- `m_axis_tdata`  out  2*DWIDTH  `[DWIDTH-1:0]` holds the older word; `[2*DWIDTH-1:DWIDTH]` holds the newer word.
- `m_axis_tkeep`  out  2  one bit per word: `2'b11` for a pair, `2'b01` for a single.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream ready.

## Operation
- Occupancy `occ = wr_ptr - rd_ptr`, computed modulo 2**(ADDRWIDTH+1). Valid range is 0..2**ADDRWIDTH.
- State machine: IDLE, FETCH, CAPTURE, PRESENT.
- IDLE:
  - `occ >= 2`: latch pair=1, go to FETCH.
  - `occ == 1` and flush counter has reached `FLUSH_CYCLES`: latch pair=0, go to FETCH.
  - otherwise stay in IDLE.
- Flush counter:
  - Increments, saturating, on every IDLE cycle with `occ == 1`.
  - Clears in any cycle where `occ != 1` or state != IDLE.
- FETCH: `ram_en=1`. Unconditionally go to CAPTURE.
- CAPTURE:
  - Register `{ram_dout2, ram_dout1}` into `tdata`. When pair=0, the high half is forced to 0.
  - Set `tkeep` from the latched pair bit; set `tvalid=1`; go to PRESENT.
- PRESENT:
  - Hold `tdata`, `tkeep` and `tvalid` stable until `tvalid & tready`.
  - On that edge: `rd_ptr += pair ? 2 : 1` (modulo 2**(ADDRWIDTH+1)), `tvalid` drops to 0, go to IDLE.
- Wrap-around:
  - When `rd_ptr[ADDRWIDTH-1:0] = 2**ADDRWIDTH-1`, the pair is the last RAM word followed by word 0. The RAM's own address increment wraps, so no special case is needed here.
  - `rd_ptr` rolls from all-ones to 0 and the wrap bit toggles correctly.
- Writes during a fetch:
  - The pair/single decision is frozen at the IDLE→FETCH transition.
  - Words written afterwards wait for the next transfer.
- `ram_en` is 0 in every state except FETCH.

## Timing
- Reset values (asynchronous, with `rst` high):
  - state=IDLE, `rd_ptr=0`, flush counter 0.
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tkeep=2'b00`.
  - `ram_en=0`.
- Latency:
  - If `wr_ptr` changes at edge k and makes `occ>=2`: FETCH in cycle k+1, CAPTURE in k+2, `tvalid=1` from k+3.
  - For a single word: `tvalid` rises FLUSH_CYCLES+3 cycles after `occ` became 1 (3 cycles when `FLUSH_CYCLES=0`).
- RAM read latency is exactly 1 cycle: data for the FETCH-cycle address is valid throughout CAPTURE.
- Throughput: at most one beat per 4 cycles (PRESENT → IDLE → FETCH → CAPTURE) with `tready` held at 1.
- If `tready` is already 1 when `tvalid` rises, the handshake completes on the first PRESENT edge.
- A reset mid-transfer drops `tvalid` immediately and loses the beat. The writer is reset by the same `rst`.

## Structure
- Shared package `axis_uart_pkg` holds:
  - the state enum (IDLE, FETCH, CAPTURE, PRESENT);
  - constants `KEEP_PAIR=2'b11` and `KEEP_SINGLE=2'b01`.
- One sub-module, `ring_flush_timer`:
  - Inputs: `occ_is_one`, `in_idle`.
  - Output: `flush_due`.
  - Saturating counter, width `$clog2(FLUSH_CYCLES+1)`, minimum 1 bit.

## Test plan
- Pair read: write 0x1111, 0x2222 at addresses 0 and 1, `tready=1` → one beat `tdata=0x22221111`, `tkeep=11`, `tvalid` 3 cycles after `wr_ptr=2`, then `rd_ptr=2`.
- Flush: `FLUSH_CYCLES=16`, write only 0xABCD → no beat for 16 idle cycles, then `tdata=0x0000ABCD`, `tkeep=01`, `rd_ptr=1`.
- Wrap-around: `ADDRWIDTH=3`, `rd_ptr=7`, write 0xAAAA at 7 and 0xBBBB at 0 → `tdata=0xBBBBAAAA`; `rd_ptr` goes 4'b0111 → 4'b1001.
- Backpressure: hold `tready=0` for 20 cycles during PRESENT → `tdata`, `tkeep` and `tvalid` stable and `rd_ptr` unchanged; the beat completes on the first cycle `tready=1`.
- Late write: a second word lands while in FETCH after a single-word decision → first beat has `tkeep=01`; the second word follows as its own beat after the flush timeout.
- Reset mid-PRESENT: assert `rst` for 1 cycle → `tvalid=0` and `rd_ptr=0` within the same cycle, `ram_en=0`.
